// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: three result sources in,
// one registered register-file write port out.
interface wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 6
);
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            ld_valid;
  logic            ld_ready;
  logic [AW-1:0]   ld_rd;
  logic [XLEN-1:0] ld_data;

  logic            fpu_valid;
  logic            fpu_ready;
  logic [AW-1:0]   fpu_rd;
  logic [XLEN-1:0] fpu_data;

  logic            we;
  logic [AW-1:0]   a3;
  logic [XLEN-1:0] wd;
  logic            idle;

  // Result producers and register-file observer.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output fpu_valid, fpu_rd, fpu_data,
    input  alu_ready, ld_ready, fpu_ready,
    input  we, a3, wd, idle
  );

  // The arbiter itself.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  fpu_valid, fpu_rd, fpu_data,
    output alu_ready, ld_ready, fpu_ready,
    output we, a3, wd, idle
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source FIFOs, round-robin
// grant, registered register-file write port.
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int AW    = 6,
  parameter int DEPTH = 2
) (
  input logic        clk,
  input logic        rstn,
  input logic        stall,
  wb_arbiter_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + XLEN;

  logic [2:0]           src_valid;
  logic [2:0][AW-1:0]   src_rd;
  logic [2:0][XLEN-1:0] src_data;

  logic [2:0] ready;
  logic [2:0] push;
  logic [2:0] pop;
  logic [2:0] nonempty;

  logic [2:0][CW-1:0] cnt_q, cnt_d;
  logic [2:0][PW-1:0] wp_q, wp_d;
  logic [2:0][PW-1:0] rp_q, rp_d;

  logic [1:0] rr_q, rr_d;

  logic            we_q, we_d;
  logic [AW-1:0]   a3_q, a3_d;
  logic [XLEN-1:0] wd_q, wd_d;

  logic [EW-1:0] mem [3][DEPTH];

  logic [1:0]    gnt;
  logic          gnt_vld;
  logic [EW-1:0] head;

  // Source index: rr plus offset, modulo 3.
  function automatic logic [1:0] rr_idx(
    input logic [1:0] base,
    input logic [1:0] off
  );
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  // Gather the three sources into indexed vectors.
  always_comb begin
    src_valid = {bus.fpu_valid, bus.ld_valid,
                 bus.alu_valid};
    src_rd[0]   = bus.alu_rd;
    src_rd[1]   = bus.ld_rd;
    src_rd[2]   = bus.fpu_rd;
    src_data[0] = bus.alu_data;
    src_data[1] = bus.ld_data;
    src_data[2] = bus.fpu_data;
  end

  // Ready from registered count only; rd 0 is
  // accepted but never stored.
  always_comb begin
    ready    = '0;
    push     = '0;
    nonempty = '0;
    for (int s = 0; s < 3; s++) begin
      nonempty[s] = (cnt_q[s] != '0);
      ready[s]    = !rstn &&
                    (cnt_q[s] < CW'(DEPTH));
      push[s]     = src_valid[s] && ready[s] &&
                    (src_rd[s] != '0);
    end
  end

  // Round-robin search; offset 0 checked last so
  // it wins as the highest-priority source.
  always_comb begin
    gnt     = 2'd0;
    gnt_vld = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      if (nonempty[rr_idx(rr_q, 2'(i))]) begin
        gnt     = rr_idx(rr_q, 2'(i));
        gnt_vld = 1'b1;
      end
    end
    head = mem[gnt][rp_q[gnt]];
  end

  // Pop only the granted head, never under stall.
  always_comb begin
    pop = '0;
    for (int s = 0; s < 3; s++) begin
      pop[s] = !stall && gnt_vld &&
               (gnt == 2'(s));
    end
  end

  // Queue pointers and counts; wrap is implicit
  // because DEPTH is a power of two.
  always_comb begin
    cnt_d = cnt_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    for (int s = 0; s < 3; s++) begin
      cnt_d[s] = cnt_q[s] + CW'(push[s])
                          - CW'(pop[s]);
      wp_d[s]  = wp_q[s] + PW'(push[s]);
      rp_d[s]  = rp_q[s] + PW'(pop[s]);
    end
  end

  // Write port and rr: load on grant, clear we
  // when nothing is queued, hold under stall.
  always_comb begin
    we_d = we_q;
    a3_d = a3_q;
    wd_d = wd_q;
    rr_d = rr_q;
    if (!stall) begin
      if (gnt_vld) begin
        we_d = 1'b1;
        a3_d = head[EW-1:XLEN];
        wd_d = head[XLEN-1:0];
        rr_d = (gnt == 2'd2) ? 2'd0
                             : gnt + 2'd1;
      end else begin
        we_d = 1'b0;
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      rr_q  <= 2'd0;
      we_q  <= 1'b0;
      a3_q  <= '0;
      wd_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      rr_q  <= rr_d;
      we_q  <= we_d;
      a3_q  <= a3_d;
      wd_q  <= wd_d;
    end
  end

  // Queue storage; not reset, pointers guard it.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (push[s]) begin
        mem[s][wp_q[s]] <= {src_rd[s], src_data[s]};
      end
    end
  end

  assign bus.alu_ready = ready[0];
  assign bus.ld_ready  = ready[1];
  assign bus.fpu_ready = ready[2];
  assign bus.we        = we_q;
  assign bus.a3        = a3_q;
  assign bus.wd        = wd_q;
  assign bus.idle      = (cnt_q == '0) && !we_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: latency,
// round-robin, backpressure, stall, reset.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rstn;
  logic stall;

  int checks = 0;
  int errors = 0;

  wb_arbiter_if #(.XLEN(32), .AW(6)) bus ();

  wb_arbiter #(
    .XLEN(32), .AW(6), .DEPTH(2)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .stall(stall),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_srcs();
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.fpu_valid = 1'b0;
  endtask

  task automatic exp_wr(input string tag,
                        input logic [5:0] a,
                        input logic [31:0] d);
    chk({tag, "_we"}, 64'(bus.we), 64'd1);
    chk({tag, "_a3"}, 64'(bus.a3), 64'(a));
    chk({tag, "_wd"}, 64'(bus.wd), 64'(d));
  endtask

  task automatic put3(input logic [5:0] r0,
                      input logic [5:0] r1,
                      input logic [5:0] r2);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = r0;
    bus.alu_data  = 32'hA000_0000 | 32'(r0);
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = r1;
    bus.ld_data   = 32'hB000_0000 | 32'(r1);
    bus.fpu_valid = 1'b1;
    bus.fpu_rd    = r2;
    bus.fpu_data  = 32'hC000_0000 | 32'(r2);
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    step();
    rstn = 1'b0;
    #1;
  endtask

  initial begin
    rstn  = 1'b1;
    stall = 1'b0;
    idle_srcs();
    bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_rd  = '0; bus.ld_data  = '0;
    bus.fpu_rd = '0; bus.fpu_data = '0;

    // Reset state.
    step();
    step();
    chk("rst_alu_rdy", 64'(bus.alu_ready), 64'd0);
    chk("rst_ld_rdy", 64'(bus.ld_ready), 64'd0);
    chk("rst_we", 64'(bus.we), 64'd0);
    chk("rst_a3", 64'(bus.a3), 64'd0);
    chk("rst_wd", 64'(bus.wd), 64'd0);
    chk("rst_idle", 64'(bus.idle), 64'd1);
    rstn = 1'b0;
    #1;
    chk("post_rst_rdy", 64'(bus.alu_ready), 64'd1);

    // Single ALU write, two-edge latency.
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 6'd5;
    bus.alu_data  = 32'hDEADBEEF;
    step();
    idle_srcs();
    chk("single_we0", 64'(bus.we), 64'd0);
    chk("single_busy", 64'(bus.idle), 64'd0);
    step();
    exp_wr("single", 6'd5, 32'hDEADBEEF);
    chk("single_idle_wr", 64'(bus.idle), 64'd0);
    step();
    chk("single_we_off", 64'(bus.we), 64'd0);
    chk("single_idle", 64'(bus.idle), 64'd1);

    // Simultaneous sources from rr = 0.
    do_reset();
    put3(6'd1, 6'd2, 6'd3);
    step();
    idle_srcs();
    step();
    exp_wr("sim_1", 6'd1, 32'hA000_0001);
    step();
    exp_wr("sim_2", 6'd2, 32'hB000_0002);
    step();
    exp_wr("sim_3", 6'd3, 32'hC000_0003);
    step();
    chk("sim_done", 64'(bus.we), 64'd0);

    // rr back at 0: same order again.
    put3(6'd4, 6'd5, 6'd6);
    step();
    idle_srcs();
    step();
    exp_wr("rr0_4", 6'd4, 32'hA000_0004);
    step();
    exp_wr("rr0_5", 6'd5, 32'hB000_0005);
    step();
    exp_wr("rr0_6", 6'd6, 32'hC000_0006);
    step();

    // LD grant moves rr to 2: FPU, ALU, LD.
    bus.ld_valid = 1'b1;
    bus.ld_rd    = 6'd9;
    bus.ld_data  = 32'h0000_0009;
    step();
    idle_srcs();
    step();
    exp_wr("rr_ld", 6'd9, 32'h0000_0009);
    put3(6'd10, 6'd11, 6'd12);
    step();
    idle_srcs();
    step();
    exp_wr("rr2_fpu", 6'd12, 32'hC000_000C);
    step();
    exp_wr("rr2_alu", 6'd10, 32'hA000_000A);
    step();
    exp_wr("rr2_ld", 6'd11, 32'hB000_000B);
    step();
    chk("rr2_done", 64'(bus.we), 64'd0);

    // Zero destination is swallowed.
    chk("zero_rdy", 64'(bus.fpu_ready), 64'd1);
    bus.fpu_valid = 1'b1;
    bus.fpu_rd    = 6'd0;
    bus.fpu_data  = 32'h12345678;
    step();
    idle_srcs();
    chk("zero_we", 64'(bus.we), 64'd0);
    chk("zero_idle", 64'(bus.idle), 64'd1);
    step();
    chk("zero_we2", 64'(bus.we), 64'd0);

    // Backpressure under stall.
    stall = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_rd    = 6'd20;
    bus.ld_data  = 32'h2020_2020;
    chk("bp_rdy0", 64'(bus.ld_ready), 64'd1);
    step();
    bus.ld_rd   = 6'd21;
    bus.ld_data = 32'h2121_2121;
    chk("bp_rdy1", 64'(bus.ld_ready), 64'd1);
    step();
    chk("bp_full", 64'(bus.ld_ready), 64'd0);
    bus.ld_rd   = 6'd22;
    bus.ld_data = 32'h2222_2222;
    step();
    chk("bp_full2", 64'(bus.ld_ready), 64'd0);
    chk("bp_we", 64'(bus.we), 64'd0);
    idle_srcs();
    stall = 1'b0;
    #1;
    chk("bp_rdy_prepop", 64'(bus.ld_ready), 64'd0);
    step();
    exp_wr("bp_1", 6'd20, 32'h2020_2020);
    chk("bp_rdy_back", 64'(bus.ld_ready), 64'd1);
    step();
    exp_wr("bp_2", 6'd21, 32'h2121_2121);
    step();
    chk("bp_done", 64'(bus.we), 64'd0);
    chk("bp_idle", 64'(bus.idle), 64'd1);

    // Stall holds the write port.
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 6'd7;
    bus.alu_data  = 32'h7777_0007;
    step();
    bus.alu_rd    = 6'd8;
    bus.alu_data  = 32'h8888_0008;
    step();
    idle_srcs();
    exp_wr("st_first", 6'd7, 32'h7777_0007);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_wr("st_hold", 6'd7, 32'h7777_0007);
    end
    stall = 1'b0;
    step();
    exp_wr("st_next", 6'd8, 32'h8888_0008);
    step();
    chk("st_done", 64'(bus.we), 64'd0);

    // Reset mid-stream discards queued work.
    stall = 1'b1;
    put3(6'd30, 6'd31, 6'd32);
    step();
    idle_srcs();
    chk("mid_busy", 64'(bus.idle), 64'd0);
    rstn = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 6'd33;
    bus.alu_data  = 32'h3333_3333;
    #1;
    chk("mid_rst_rdy", 64'(bus.alu_ready), 64'd0);
    step();
    idle_srcs();
    rstn  = 1'b0;
    stall = 1'b0;
    #1;
    chk("mid_we", 64'(bus.we), 64'd0);
    chk("mid_idle", 64'(bus.idle), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_nowr", 64'(bus.we), 64'd0);
    end
    chk("mid_idle_end", 64'(bus.idle), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
